// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed-priority pipelined scan-out reads,
// CPU req/ack access with a starvation guard that drops video reads.
module vram_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_miss,
    output logic [7:0]    miss_cnt,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, CPU_WR, CPU_RD, ACK} state_t;
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    state_t        state_q, state_d;
    logic          rd_ph_q, rd_ph_d;
    logic [7:0]    wait_q, wait_d;
    logic [7:0]    miss_q, miss_d;
    logic          vmiss_q, vmiss_d;
    logic          vid_p1_q, vid_p2_q, vvalid_q;
    logic [DW-1:0] vrd_q, vrd_d;
    logic [DW-1:0] crd_q, crd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          cpu_elig, starve, ovr, cpu_gnt, vid_gnt, cap_cpu;

    assign cpu_ack = (state_q == ACK);

    always_comb begin
        cpu_elig = (state_q == IDLE) && cpu_req && !cpu_ack;
        starve   = (wait_q >= MAX_W);
        ovr      = cpu_elig && starve;
        cpu_gnt  = cpu_elig && (starve || !vid_req);
        vid_gnt  = vid_req && !ovr;
    end

    always_comb begin
        state_d = state_q;
        rd_ph_d = rd_ph_q;
        cap_cpu = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_gnt) begin
                    state_d = cpu_we ? CPU_WR : CPU_RD;
                    rd_ph_d = 1'b0;
                end
            end
            CPU_WR: state_d = ACK;
            CPU_RD: begin
                // second cycle in CPU_RD is the one where ram_rdata is valid
                if (rd_ph_q) begin
                    state_d = ACK;
                    cap_cpu = 1'b1;
                end else begin
                    rd_ph_d = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (!cpu_req || cpu_gnt)
            wait_d = 8'd0;
        else if (wait_q == 8'hFF)
            wait_d = wait_q;
        else
            wait_d = wait_q + 8'd1;
        vmiss_d = ovr && vid_req;
        miss_d  = (vmiss_d && miss_q != 8'hFF) ? miss_q + 8'd1 : miss_q;
        addr_d  = addr_q;
        if (vid_gnt)
            addr_d = vid_addr;
        else if (cpu_gnt)
            addr_d = cpu_addr;
        we_d    = cpu_gnt && cpu_we;
        wdata_d = we_d ? cpu_wdata : wdata_q;
        vrd_d   = vid_p2_q ? ram_rdata : vrd_q;
        crd_d   = cap_cpu ? ram_rdata : crd_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            rd_ph_q  <= 1'b0;
            wait_q   <= 8'd0;
            miss_q   <= 8'd0;
            vmiss_q  <= 1'b0;
            vid_p1_q <= 1'b0;
            vid_p2_q <= 1'b0;
            vvalid_q <= 1'b0;
            vrd_q    <= '0;
            crd_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ph_q  <= rd_ph_d;
            wait_q   <= wait_d;
            miss_q   <= miss_d;
            vmiss_q  <= vmiss_d;
            vid_p1_q <= vid_gnt;
            vid_p2_q <= vid_p1_q;
            vvalid_q <= vid_p2_q;
            vrd_q    <= vrd_d;
            crd_q    <= crd_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    assign vid_valid = vvalid_q;
    assign vid_rdata = vrd_q;
    assign vid_miss  = vmiss_q;
    assign miss_cnt  = miss_q;
    assign cpu_rdata = crd_q;
    assign ram_addr  = addr_q;
    assign ram_we    = we_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus random traffic,
// checked against an edge-by-edge model of the grant rules.
module tb_vram_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_valid;
    logic [DW-1:0] vid_rdata;
    logic          vid_miss;
    logic [7:0]    miss_cnt;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .resetn(resetn),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_valid(vid_valid), .vid_rdata(vid_rdata),
        .vid_miss(vid_miss), .miss_cnt(miss_cnt),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [7:0] memv(input int i);
        if (i == 32'h123) return 8'h5A;
        return 8'((i * 29 + 7) ^ (i >> 5));
    endfunction

    // synchronous single-port RAM, preloaded on the first edge
    logic [7:0] mem [0:4095];
    bit loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= memv(i);
            loaded <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // reference model state
    logic [7:0]  shadow [0:4095];
    int          cyc = 0;
    int          wt, free_e, mcnt, last_ack;
    bit          e_vv [8];
    logic [7:0]  e_vd [8];
    bit          e_ack [8];
    bit          e_ackrd [8];
    logic [7:0]  e_cd [8];
    bit          e_miss [8];
    bit          e_we;
    logic [11:0] e_addr;
    logic [7:0]  e_wd;

    task automatic model_reset();
        wt = 0; free_e = 0; mcnt = 0; last_ack = -1;
        e_we = 0; e_addr = 0; e_wd = 0;
        for (int i = 0; i < 8; i++) begin
            e_vv[i] = 0; e_ack[i] = 0; e_miss[i] = 0;
        end
    endtask

    task automatic zero_check();
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_vid_rdata", vid_rdata, 0);
        chk("rst_vid_miss", vid_miss, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
    endtask

    task automatic reset_hold(input int n);
        resetn = 1'b0;
        model_reset();
        #1 zero_check();
        repeat (n) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            zero_check();
        end
        resetn = 1'b1;
    endtask

    // apply one edge: predict from the grant rules, then compare
    task automatic step();
        int e;
        int s;
        bit elig, ovr, vg, cg;
        e = cyc + 1;
        s = e % 8;
        elig = cpu_req && (e >= free_e);
        ovr  = elig && (wt >= MW);
        vg   = vid_req && !ovr;
        cg   = ovr || (elig && !vid_req);
        e_miss[s] = ovr && vid_req;
        if (e_miss[s] && mcnt < 255) mcnt++;
        e_we = cg && cpu_we;
        if (vg) e_addr = vid_addr;
        else if (cg) e_addr = cpu_addr;
        if (e_we) e_wd = cpu_wdata;
        if (vg) begin
            e_vv[(e + 2) % 8] = 1;
            e_vd[(e + 2) % 8] = shadow[vid_addr];
        end
        if (cg) begin
            if (cpu_we) begin
                shadow[cpu_addr] = cpu_wdata;
                e_ack[(e + 1) % 8] = 1;
                e_ackrd[(e + 1) % 8] = 0;
                free_e = e + 3;
            end else begin
                e_ack[(e + 2) % 8] = 1;
                e_ackrd[(e + 2) % 8] = 1;
                e_cd[(e + 2) % 8] = shadow[cpu_addr];
                free_e = e + 4;
            end
        end
        if (!cpu_req || cg) wt = 0;
        else if (wt < 255) wt++;
        @(posedge clk);
        cyc = e;
        @(negedge clk);
        chk("vid_valid", vid_valid, e_vv[s]);
        if (e_vv[s]) chk("vid_rdata", vid_rdata, e_vd[s]);
        chk("vid_miss", vid_miss, e_miss[s]);
        chk("miss_cnt", miss_cnt, mcnt);
        chk("cpu_ack", cpu_ack, e_ack[s]);
        if (e_ack[s]) begin
            last_ack = e;
            if (e_ackrd[s]) chk("cpu_rdata", cpu_rdata, e_cd[s]);
        end
        chk("ram_we", ram_we, e_we);
        chk("ram_addr", ram_addr, e_addr);
        if (e_we) chk("ram_wdata", ram_wdata, e_wd);
        e_vv[s] = 0;
        e_ack[s] = 0;
    endtask

    // vmode: 0 no video, 1 continuous, 2 first five cycles only, 3 random
    task automatic cpu_run(input bit we, input int addr, input int wd,
                           input int vmode);
        int n;
        n = 0;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = 12'(addr);
        cpu_wdata = 8'(wd);
        do begin
            unique case (vmode)
                0: vid_req = 1'b0;
                1: vid_req = 1'b1;
                2: vid_req = (n < 5);
                default: vid_req = ($urandom % 2 == 0);
            endcase
            vid_addr = (vmode == 2) ? 12'(12'h200 + n) : 12'($urandom);
            step();
            n++;
        end while (last_ack != cyc && n < 600);
        if (last_ack != cyc) chk("cpu_timeout", 1, 0);
    endtask

    initial begin
        int busy;
        for (int i = 0; i < 4096; i++) shadow[i] = memv(i);
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        vid_req = 0; vid_addr = 0;
        reset_hold(2);

        // reset with a video read in flight
        vid_req = 1; vid_addr = 12'h010;
        step();
        vid_req = 0;
        reset_hold(4);

        // single and back-to-back video reads
        vid_req = 1; vid_addr = 12'h123;
        step();
        vid_req = 0;
        repeat (4) step();
        for (int i = 0; i < 8; i++) begin
            vid_req = 1; vid_addr = 12'(12'h100 + i);
            step();
        end
        vid_req = 0;
        repeat (4) step();

        // CPU write then read, video idle
        cpu_run(1'b1, 12'h040, 8'hA5, 0);
        cpu_req = 0;
        step();
        cpu_run(1'b0, 12'h040, 0, 0);
        chk("t3_rdata", cpu_rdata, 8'hA5);
        cpu_req = 0;
        step();

        // contention below the starvation threshold
        cpu_run(1'b0, 12'h040, 0, 2);
        cpu_req = 0; vid_req = 0;
        repeat (3) step();

        // starvation override
        cpu_run(1'b1, 12'h055, 8'h3C, 1);
        chk("t5_miss_cnt", miss_cnt, 1);
        cpu_req = 0; vid_req = 1;
        repeat (3) step();

        // saturation with cpu_req held through every ack
        for (int i = 0; i < 300; i++)
            cpu_run(1'($urandom), int'($urandom % 4096), int'($urandom), 1);
        chk("t6_sat", miss_cnt, 255);
        cpu_req = 0; vid_req = 0;
        repeat (4) step();
        reset_hold(2);

        // random mixed traffic on a small address window
        busy = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy) begin
                if ($urandom % 3 == 0) begin
                    cpu_req = 1; cpu_we = 1'($urandom);
                    cpu_addr = 12'($urandom % 32);
                    cpu_wdata = 8'($urandom);
                    busy = 1;
                end else begin
                    cpu_req = 0;
                end
            end
            vid_req = (i < 1500) ? ($urandom % 4 != 0) : ($urandom % 20 != 0);
            vid_addr = 12'($urandom % 32);
            step();
            if (busy && last_ack == cyc) busy = 0;
        end
        cpu_req = 0; vid_req = 0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
